// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle control unit for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port, with a
// ready/request handshake guarded by a wait-cycle timeout, a sticky
// illegal-instruction trap and a retired-instruction counter.
module mips_mc_ctrl #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                im_req,
  output logic                dm_req,
  output logic                dm_we,
  output logic                ir_we,
  output logic                pc_we,
  output logic [1:0]          npc_sel,
  output logic                reg_we,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wd_sel,
  output logic                alu_src,
  output logic [1:0]          ext_op,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                bus_err,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;

  // The wait counter only ever has to reach MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t              cur_state, nxt_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_hit;

  logic                is_rtype, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic                r_ok, exec_legal;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [ALU_OP_W-1:0] ex_alu_op;
  logic                ex_alu_src;
  logic [1:0]          ex_ext_op;

  logic                im_req_c, dm_req_c, dm_we_c, ir_we_c, pc_we_c, reg_we_c;
  logic                retire, set_illegal, set_bus_err;

  assign is_rtype = (op == OP_RTYPE);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);

  assign exec_legal = (is_rtype && r_ok) || is_ori || is_lui || is_lw || is_sw || is_beq;

  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  // R-type funct decode: ALU operation and whether the funct is supported.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    r_ok     = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADDU: r_alu_op = ALU_ADD;
      FN_SUBU: r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: r_ok     = 1'b0;
    endcase
  end

  // Datapath steering used in EXEC and held through WB.
  always_comb begin
    ex_alu_op  = ALU_ADD;
    ex_alu_src = 1'b0;
    ex_ext_op  = EXT_ZERO;
    if (is_rtype) begin
      ex_alu_op = r_alu_op;
    end else if (is_ori) begin
      ex_ext_op  = EXT_ZERO;
      ex_alu_src = 1'b1;
      ex_alu_op  = ALU_OR;
    end else if (is_lui) begin
      ex_ext_op  = EXT_LUI;
      ex_alu_src = 1'b1;
      ex_alu_op  = ALU_OR;
    end else if (is_lw || is_sw) begin
      ex_ext_op  = EXT_SIGN;
      ex_alu_src = 1'b1;
      ex_alu_op  = ALU_ADD;
    end else if (is_beq) begin
      ex_alu_op  = ALU_SUB;
      ex_alu_src = 1'b0;
    end
  end

  // Next-state and control-output logic.
  always_comb begin
    nxt_state   = cur_state;
    im_req_c    = 1'b0;
    dm_req_c    = 1'b0;
    dm_we_c     = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    reg_we_c    = 1'b0;
    npc_sel     = NPC_SEQ;
    reg_dst     = DST_RT;
    wd_sel      = WD_ALU;
    alu_src     = 1'b0;
    ext_op      = EXT_ZERO;
    alu_op      = ALU_ADD;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (cur_state)
      S_FETCH: begin
        im_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c   = 1'b1;
          pc_we_c   = 1'b1;
          npc_sel   = NPC_SEQ;
          nxt_state = S_DECODE;
        end else if (wait_hit) begin
          set_bus_err = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we_c   = 1'b1;
          npc_sel   = NPC_JUMP;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else if (exec_legal) begin
          nxt_state = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_op  = ex_alu_op;
        alu_src = ex_alu_src;
        ext_op  = ex_ext_op;
        if (is_beq) begin
          pc_we_c   = zero;
          npc_sel   = NPC_BRANCH;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else if (is_lw || is_sw) begin
          nxt_state = S_MEM;
        end else if (exec_legal) begin
          nxt_state = S_WB;
        end else begin
          // IR is stable after DECODE, so this only guards against corruption.
          nxt_state = S_TRAP;
        end
      end
      S_MEM: begin
        dm_req_c = 1'b1;
        dm_we_c  = is_sw;
        if (mem_ready) begin
          if (is_sw) begin
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            nxt_state = S_WB;
          end
        end else if (wait_hit) begin
          set_bus_err = 1'b1;
          nxt_state   = S_TRAP;
        end
      end
      S_WB: begin
        reg_we_c  = 1'b1;
        reg_dst   = is_rtype ? DST_RD : DST_RT;
        wd_sel    = is_lw ? WD_MEM : WD_ALU;
        alu_op    = ex_alu_op;
        alu_src   = ex_alu_src;
        ext_op    = ex_ext_op;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_TRAP: begin
        nxt_state = S_TRAP;
      end
      default: begin
        nxt_state = S_TRAP;
      end
    endcase
  end

  // NOTE: reset only moves the state register, so the request and write
  // enables are gated with rst to stay quiet for the whole reset pulse.
  assign im_req = im_req_c & ~rst;
  assign dm_req = dm_req_c & ~rst;
  assign dm_we  = dm_we_c  & ~rst;
  assign ir_we  = ir_we_c  & ~rst;
  assign pc_we  = pc_we_c  & ~rst;
  assign reg_we = reg_we_c & ~rst;
  assign state  = cur_state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Handshake wait counter: cleared on any state change, counts stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (nxt_state != cur_state) begin
      wait_cnt <= '0;
    end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky trap flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (set_illegal) illegal <= 1'b1;
      if (set_bus_err) bus_err <= 1'b1;
    end
  end

  // Retired-instruction counter, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: table-driven, hand-written and randomized checks of
// mips_mc_ctrl built with MEM_TIMEOUT=4 and CNT_W=4.
module tb_mips_mc_ctrl;

  localparam int T_OUT = 4;
  localparam int CW    = 4;

  logic          clk, rst;
  logic [5:0]    op, funct;
  logic          zero, mem_ready;
  logic          im_req, dm_req, dm_we, ir_we, pc_we, reg_we, alu_src;
  logic [1:0]    npc_sel, reg_dst, wd_sel, ext_op;
  logic [2:0]    alu_op, state;
  logic          illegal, bus_err;
  logic [CW-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  mips_mc_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src(alu_src), .ext_op(ext_op),
    .alu_op(alu_op), .state(state), .illegal(illegal), .bus_err(bus_err),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full per-cycle control vector, in the order of the concatenation below.
  typedef struct packed {
    logic [2:0] st;
    logic       im_req, dm_req, dm_we, ir_we, pc_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
  } ctl_t;

  ctl_t dut_ctl;
  assign dut_ctl = ctl_t'({state, im_req, dm_req, dm_we, ir_we, pc_we, npc_sel,
                           reg_we, reg_dst, wd_sel, alu_src, ext_op, alu_op});

  logic [5:0] enables;
  assign enables = {im_req, dm_req, dm_we, ir_we, pc_we, reg_we};

  typedef struct packed {
    ctl_t exp;
    logic ready;
  } cyc_t;

  cyc_t trace[$];

  typedef enum int {
    I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J,
    I_BAD_R, I_BAD_OP, I_NUM
  } instr_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         len;
    int         path;   // one hex digit per cycle, first cycle most significant
    bit         trap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic r);
    mem_ready = r;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_enables", 32'(enables), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    tick();
    tick();
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] alu_of(input instr_t i);
    case (i)
      I_SUBU, I_BEQ:        return 3'd1;
      I_AND:                return 3'd2;
      I_OR, I_ORI, I_LUI:   return 3'd3;
      I_SLT:                return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic src_of(input instr_t i);
    return (i == I_ORI || i == I_LUI || i == I_LW || i == I_SW);
  endfunction

  function automatic logic [1:0] ext_of(input instr_t i);
    if (i == I_LUI) return 2'd2;
    if (i == I_LW || i == I_SW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic ctl_t blank(input logic [2:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  task automatic encode(input instr_t i, output logic [5:0] o, output logic [5:0] f);
    logic [5:0] bad_fn [6] = '{6'h20, 6'h22, 6'h00, 6'h27, 6'h2B, 6'h08};
    logic [5:0] bad_op [8] = '{6'h01, 6'h03, 6'h05, 6'h08, 6'h09, 6'h3F, 6'h20, 6'h28};
    o = 6'h00;
    f = 6'($urandom);
    case (i)
      I_ADDU:   f = 6'h21;
      I_SUBU:   f = 6'h23;
      I_AND:    f = 6'h24;
      I_OR:     f = 6'h25;
      I_SLT:    f = 6'h2A;
      I_ORI:    o = 6'h0D;
      I_LUI:    o = 6'h0F;
      I_LW:     o = 6'h23;
      I_SW:     o = 6'h2B;
      I_BEQ:    o = 6'h04;
      I_J:      o = 6'h02;
      I_BAD_R:  f = bad_fn[$urandom_range(0, 5)];
      default:  o = bad_op[$urandom_range(0, 7)];
    endcase
  endtask

  task automatic push(input ctl_t c, input logic r);
    cyc_t e;
    e.exp   = c;
    e.ready = r;
    trace.push_back(e);
  endtask

  // Builds the expected cycle-by-cycle trace of one instruction.
  task automatic build_trace(input instr_t ins, input logic z, input int fw, input int mw,
                             output bit trap_ill, output bit trap_bus, output bit retired);
    ctl_t c;
    trap_ill = 0;
    trap_bus = 0;
    retired  = 0;
    trace.delete();
    // fetch handshake
    c = blank(3'd0);
    c.im_req = 1'b1;
    for (int k = 0; k < fw && k < T_OUT; k++) push(c, 1'b0);
    if (fw >= T_OUT) begin trap_bus = 1; return; end
    c.ir_we = 1'b1;
    c.pc_we = 1'b1;
    push(c, 1'b1);
    // decode
    c = blank(3'd1);
    if (ins == I_J) begin
      c.pc_we = 1'b1;
      c.npc_sel = 2'd2;
      push(c, 1'($urandom_range(0, 1)));
      retired = 1;
      return;
    end
    push(c, 1'($urandom_range(0, 1)));
    if (ins == I_BAD_R || ins == I_BAD_OP) begin trap_ill = 1; return; end
    // execute
    c = blank(3'd2);
    c.alu_op  = alu_of(ins);
    c.alu_src = src_of(ins);
    c.ext_op  = ext_of(ins);
    if (ins == I_BEQ) begin
      c.pc_we = z;
      c.npc_sel = 2'd1;
      push(c, 1'($urandom_range(0, 1)));
      retired = 1;
      return;
    end
    push(c, 1'($urandom_range(0, 1)));
    // memory handshake
    if (ins == I_LW || ins == I_SW) begin
      c = blank(3'd3);
      c.dm_req = 1'b1;
      c.dm_we  = (ins == I_SW);
      for (int k = 0; k < mw && k < T_OUT; k++) push(c, 1'b0);
      if (mw >= T_OUT) begin trap_bus = 1; return; end
      push(c, 1'b1);
      if (ins == I_SW) begin retired = 1; return; end
    end
    // write back
    c = blank(3'd4);
    c.reg_we  = 1'b1;
    c.reg_dst = (ins <= I_SLT) ? 2'd1 : 2'd0;
    c.wd_sel  = (ins == I_LW) ? 2'd1 : 2'd0;
    c.alu_op  = alu_of(ins);
    c.alu_src = src_of(ins);
    c.ext_op  = ext_of(ins);
    push(c, 1'($urandom_range(0, 1)));
    retired = 1;
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int      st, n_im, n_dm;
    logic    any_we;
    logic [1:0] wb_wd;
    instr_t  ins;
    logic [5:0] o, f;
    logic    z;
    bit      t_ill, t_bus, ret;
    int      lw_rdy [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_state", 32'(state), 32'd0);
    check("init_enables", 32'(enables), 32'd0);
    check("init_count", 32'(instr_count), 32'd0);
    check("init_flags", 32'({illegal, bus_err}), 32'd0);
    rst = 1'b0;

    // ---------------- table-driven, mem_ready tied high ----------------
    vecs.push_back('{"addu", 6'h00, 6'h21, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"subu", 6'h00, 6'h23, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"and",  6'h00, 6'h24, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"or",   6'h00, 6'h25, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"slt",  6'h00, 6'h2A, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"ori",  6'h0D, 6'h00, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"lui",  6'h0F, 6'h3F, 1'b0, 4, 'h0124,  1'b0});
    vecs.push_back('{"lw",   6'h23, 6'h00, 1'b0, 5, 'h01234, 1'b0});
    vecs.push_back('{"sw",   6'h2B, 6'h00, 1'b0, 4, 'h0123,  1'b0});
    vecs.push_back('{"beq1", 6'h04, 6'h00, 1'b1, 3, 'h012,   1'b0});
    vecs.push_back('{"beq0", 6'h04, 6'h00, 1'b0, 3, 'h012,   1'b0});
    vecs.push_back('{"j",    6'h02, 6'h00, 1'b0, 2, 'h01,    1'b0});
    vecs.push_back('{"badfn",6'h00, 6'h20, 1'b0, 2, 'h01,    1'b1});
    vecs.push_back('{"badop",6'h3F, 6'h00, 1'b0, 2, 'h01,    1'b1});

    foreach (vecs[v]) begin
      op = vecs[v].op;
      funct = vecs[v].funct;
      zero = vecs[v].z;
      for (int i = 0; i < vecs[v].len; i++) begin
        st = (vecs[v].path >> (4 * (vecs[v].len - 1 - i))) & 7;
        settle(1'b1);
        check({vecs[v].name, "_state"}, 32'(state), 32'(st));
        check({vecs[v].name, "_reg_we"}, 32'(reg_we), 32'(st == 4));
        tick();
      end
      settle(1'b1);
      if (vecs[v].trap) begin
        check({vecs[v].name, "_trap"}, 32'(state), 32'd7);
        check({vecs[v].name, "_illegal"}, 32'(illegal), 32'd1);
        do_reset();
      end else begin
        exp_cnt = (exp_cnt + 1) % 16;
        check({vecs[v].name, "_end"}, 32'(state), 32'd0);
        check({vecs[v].name, "_count"}, 32'(instr_count), 32'(exp_cnt));
      end
    end

    // ---------------- lw with 3 fetch and 2 memory wait cycles ----------------
    do_reset();
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    n_im = 0; n_dm = 0; any_we = 1'b0; wb_wd = 2'd3;
    for (int i = 0; i < 10; i++) begin
      settle(1'(lw_rdy[i]));
      if (im_req) n_im++;
      if (dm_req) n_dm++;
      if (dm_we) any_we = 1'b1;
      if (state == 3'd4) wb_wd = wd_sel;
      tick();
    end
    settle(1'b0);
    check("lw_im_cycles", 32'(n_im), 32'd4);
    check("lw_dm_cycles", 32'(n_dm), 32'd3);
    check("lw_dm_we", 32'(any_we), 32'd0);
    check("lw_wd_sel", 32'(wb_wd), 32'd1);
    check("lw_end_state", 32'(state), 32'd0);
    check("lw_count", 32'(instr_count), 32'd1);

    // ---------------- beq taken / not taken ----------------
    for (int b = 1; b >= 0; b--) begin
      do_reset();
      op = 6'h04; funct = 6'h00; zero = 1'(b);
      settle(1'b1); tick();
      settle(1'b1); tick();
      settle(1'b1);
      check("beq_exec_state", 32'(state), 32'd2);
      check("beq_pc_we", 32'(pc_we), 32'(b));
      check("beq_npc_sel", 32'(npc_sel), 32'd1);
      check("beq_alu_op", 32'(alu_op), 32'd1);
      tick();
      settle(1'b0);
      check("beq_end_state", 32'(state), 32'd0);
      check("beq_count", 32'(instr_count), 32'd1);
    end

    // ---------------- undefined opcode trap ----------------
    do_reset();
    op = 6'h3F; funct = 6'h21;
    settle(1'b1); tick();
    settle(1'b1); tick();
    for (int i = 0; i < 20; i++) begin
      settle(1'($urandom_range(0, 1)));
      check("trap_hold", 32'({state, enables}), 32'({3'd7, 6'd0}));
      tick();
    end
    check("trap_illegal", 32'(illegal), 32'd1);
    check("trap_bus_err", 32'(bus_err), 32'd0);
    do_reset();

    // ---------------- sw timeout and last-cycle rescue ----------------
    for (int rescue = 0; rescue < 2; rescue++) begin
      do_reset();
      op = 6'h2B; funct = 6'h00;
      settle(1'b1); tick();
      settle(1'b1); tick();
      settle(1'b1); tick();
      for (int i = 0; i < 4; i++) begin
        settle((rescue == 1) && (i == 3));
        check("sw_mem_wait", 32'({state, dm_req, dm_we}), 32'({3'd3, 2'b11}));
        tick();
      end
      settle(1'b0);
      if (rescue == 0) begin
        check("sw_to_state", 32'(state), 32'd7);
        check("sw_to_bus_err", 32'(bus_err), 32'd1);
        check("sw_to_dm_req", 32'(dm_req), 32'd0);
        check("sw_to_count", 32'(instr_count), 32'd0);
      end else begin
        check("sw_ok_state", 32'(state), 32'd0);
        check("sw_ok_bus_err", 32'(bus_err), 32'd0);
        check("sw_ok_count", 32'(instr_count), 32'd1);
      end
    end

    // ---------------- counter wrap over 17 jumps ----------------
    do_reset();
    op = 6'h02; funct = 6'h00;
    for (int i = 0; i < 17; i++) begin
      settle(1'b1); tick();
      settle(1'b0);
      check("j_pc_we", 32'({pc_we, npc_sel}), 32'({1'b1, 2'd2}));
      tick();
    end
    settle(1'b0);
    check("j_wrap_count", 32'(instr_count), 32'd1);

    // ---------------- reset during a memory wait ----------------
    do_reset();
    op = 6'h23; funct = 6'h00;
    settle(1'b1); tick();
    settle(1'b1); tick();
    settle(1'b1); tick();
    settle(1'b0);
    check("abort_pre_dm_req", 32'(dm_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_dm_req", 32'(dm_req), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;

    // ---------------- randomized instruction stream ----------------
    for (int n = 0; n < 250; n++) begin
      ins = instr_t'($urandom_range(0, I_NUM - 1));
      encode(ins, o, f);
      z = 1'($urandom_range(0, 1));
      build_trace(ins, z, pick_wait(), pick_wait(), t_ill, t_bus, ret);
      op = o; funct = f; zero = z;
      foreach (trace[i]) begin
        settle(trace[i].ready);
        check("rand_ctl", 32'(dut_ctl), 32'(trace[i].exp));
        tick();
      end
      settle(1'($urandom_range(0, 1)));
      if (t_ill || t_bus) begin
        check("rand_trap_ctl", 32'(dut_ctl), 32'(blank(3'd7)));
        check("rand_trap_flags", 32'({illegal, bus_err}), 32'({t_ill, t_bus}));
        do_reset();
      end else begin
        if (ret) exp_cnt = (exp_cnt + 1) % 16;
        check("rand_end_state", 32'(state), 32'd0);
        check("rand_count", 32'(instr_count), 32'(exp_cnt));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
